// File: rtl/register_map_sync.sv
// Register map between an SPI slave and user logic: synchronised strobes, config R/W, coherent status snapshots.
// Optional sticky status accumulation is built when REG_MAP_STATUS_STICKY_EN is defined.
module register_map_sync #(
   parameter int unsigned ADDR_WIDTH     = 7,
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned NUM_CONFIG_REG = 96,
   parameter int unsigned NUM_STATUS_REG = 32,
   parameter logic [DATA_WIDTH*NUM_CONFIG_REG-1:0] CONFIG_RESET = '0,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic                                 clk_i,
   input  logic                                 rstn_n,
   input  logic [ADDR_WIDTH-1:0]                addr_i,
   input  logic [DATA_WIDTH-1:0]                write_data_i,
   input  logic                                 write_en_i,
   input  logic                                 read_en_i,
   output logic [DATA_WIDTH-1:0]                read_data_o,
   output logic [DATA_WIDTH*NUM_CONFIG_REG-1:0] config_bus_o,
   input  logic [DATA_WIDTH*NUM_STATUS_REG-1:0] status_bus_i,
   output logic                                 write_ack_o,
   output logic [7:0]                           err_count_o
);

   localparam int unsigned CFG_W = DATA_WIDTH * NUM_CONFIG_REG;
   localparam int unsigned STS_W = DATA_WIDTH * NUM_STATUS_REG;
   localparam logic [ADDR_WIDTH:0] CFG_END = (ADDR_WIDTH + 1)'(NUM_CONFIG_REG);
   localparam logic [ADDR_WIDTH:0] STS_END = (ADDR_WIDTH + 1)'(NUM_CONFIG_REG + NUM_STATUS_REG);

   if (NUM_CONFIG_REG + NUM_STATUS_REG > 2 ** ADDR_WIDTH) begin : g_bad_map
      $error("register_map_sync: register count exceeds the address space");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("register_map_sync: SYNC_STAGES must be at least 2");
   end

   logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
   logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
   logic                   wr_last_q, wr_last_d;
   logic                   rd_last_q, rd_last_d;
   logic                   wr_p, rd_p;

   logic [CFG_W-1:0]       cfg_q, cfg_d;
   logic [STS_W-1:0]       snap_q, snap_d;
   logic [STS_W-1:0]       load_val;
   logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
   logic                   ack_q, ack_d;
   logic [7:0]             err_q, err_d;

   logic [ADDR_WIDTH:0]    addr_ext;
   logic [ADDR_WIDTH-1:0]  sts_idx;
   logic                   is_cfg, is_sts, is_unm;
   logic                   sts_base_rd;
   int unsigned            cfg_off, sts_off;

   // Strobes are level-held from another clock domain; a rising edge after the last stage is one access.
   always_comb begin
      wr_sync_d = {wr_sync_q[SYNC_STAGES-2:0], write_en_i};
      rd_sync_d = {rd_sync_q[SYNC_STAGES-2:0], read_en_i};
      wr_last_d = wr_sync_q[SYNC_STAGES-1];
      rd_last_d = rd_sync_q[SYNC_STAGES-1];
      wr_p      = wr_sync_q[SYNC_STAGES-1] & ~wr_last_q;
      rd_p      = rd_sync_q[SYNC_STAGES-1] & ~rd_last_q;
   end

   always_comb begin
      addr_ext    = {1'b0, addr_i};
      is_cfg      = (addr_ext < CFG_END);
      is_sts      = !is_cfg && (addr_ext < STS_END);
      is_unm      = !is_cfg && !is_sts;
      sts_idx     = addr_i - CFG_END[ADDR_WIDTH-1:0];
      cfg_off     = 32'(addr_i) * DATA_WIDTH;
      sts_off     = 32'(sts_idx) * DATA_WIDTH;
      sts_base_rd = rd_p && is_sts && (sts_idx == '0);
   end

`ifdef REG_MAP_STATUS_STICKY_EN
   logic [STS_W-1:0] acc_q, acc_d;

   // Base read hands the accumulated 1s to the snapshot and restarts from live status, so nothing is dropped.
   always_comb begin
      load_val = acc_q | status_bus_i;
      acc_d    = sts_base_rd ? status_bus_i : (acc_q | status_bus_i);
   end

   always_ff @(posedge clk_i or negedge rstn_n) begin
      if (!rstn_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
`else
   always_comb begin
      load_val = status_bus_i;
   end
`endif

   always_comb begin
      cfg_d   = cfg_q;
      snap_d  = snap_q;
      rdata_d = rdata_q;
      ack_d   = 1'b0;
      err_d   = err_q;

      if (wr_p && is_cfg) begin
         cfg_d[cfg_off +: DATA_WIDTH] = write_data_i;
         ack_d                        = 1'b1;
      end

      // Reads use cfg_q, so a write landing in the same cycle returns the pre-write value.
      if (rd_p) begin
         if (is_cfg) begin
            rdata_d = cfg_q[cfg_off +: DATA_WIDTH];
         end else if (sts_base_rd) begin
            snap_d  = load_val;
            rdata_d = load_val[DATA_WIDTH-1:0];
         end else if (is_sts) begin
            rdata_d = snap_q[sts_off +: DATA_WIDTH];
         end else begin
            rdata_d = '0;
         end
      end

      // Both strobes share one address, so a cycle adds at most one error.
      if ((wr_p || rd_p) && is_unm && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_n) begin
      if (!rstn_n) begin
         wr_sync_q <= '0;
         rd_sync_q <= '0;
         wr_last_q <= 1'b0;
         rd_last_q <= 1'b0;
         cfg_q     <= CONFIG_RESET;
         snap_q    <= '0;
         rdata_q   <= '0;
         ack_q     <= 1'b0;
         err_q     <= 8'h00;
      end else begin
         wr_sync_q <= wr_sync_d;
         rd_sync_q <= rd_sync_d;
         wr_last_q <= wr_last_d;
         rd_last_q <= rd_last_d;
         cfg_q     <= cfg_d;
         snap_q    <= snap_d;
         rdata_q   <= rdata_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
      end
   end

   assign config_bus_o = cfg_q;
   assign read_data_o  = rdata_q;
   assign write_ack_o  = ack_q;
   assign err_count_o  = err_q;

endmodule

// File: tb/tb_register_map_sync.sv
// Directed bench for register_map_sync: vector table for config/status accesses plus hand sequences for timing corners.
module tb_register_map_sync;

   localparam int CW = 96 * 8;
   localparam logic [CW-1:0] CR = 768'hA5 << 40;

   logic          clk = 1'b0;
   logic          rstn_n = 1'b0;
   logic [6:0]    addr = '0;
   logic [7:0]    wdata = '0;
   logic          write_en = 1'b0;
   logic          read_en = 1'b0;
   logic [7:0]    read_data;
   logic [CW-1:0] config_bus;
   logic [127:0]  status_bus = '0;
   logic          write_ack;
   logic [7:0]    err_count;

   int n_cmp = 0;
   int n_bad = 0;
   logic [CW-1:0] exp_cfg;

   typedef struct {
      bit         wr;
      bit         rd;
      logic [6:0] a;
      logic [7:0] d;
      int         acks;
      logic [7:0] rdata;
   } vec_t;
   vec_t vecs[10];

   register_map_sync #(
      .ADDR_WIDTH(7), .DATA_WIDTH(8), .NUM_CONFIG_REG(96), .NUM_STATUS_REG(16),
      .CONFIG_RESET(CR), .SYNC_STAGES(2)
   ) dut (
      .clk_i(clk), .rstn_n(rstn_n), .addr_i(addr), .write_data_i(wdata),
      .write_en_i(write_en), .read_en_i(read_en), .read_data_o(read_data),
      .config_bus_o(config_bus), .status_bus_i(status_bus),
      .write_ack_o(write_ack), .err_count_o(err_count)
   );

   always #5 clk = ~clk;

   task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chkw(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic access(input bit wr, input bit rd, input logic [6:0] a, input logic [7:0] d,
                         input int hold, output int acks);
      acks = 0;
      @(negedge clk);
      addr = a; wdata = d; write_en = wr; read_en = rd;
      repeat (hold) begin
         @(negedge clk);
         acks += int'(write_ack);
      end
      write_en = 1'b0; read_en = 1'b0;
      repeat (5) begin
         @(negedge clk);
         acks += int'(write_ack);
      end
   endtask

   initial begin
      int acks;
      vecs[0] = '{0, 1, 7'd3,  8'h00, 0, 8'h5C};
      vecs[1] = '{0, 1, 7'd5,  8'h00, 0, 8'hA5};
      vecs[2] = '{1, 0, 7'd0,  8'h01, 1, 8'h00};
      vecs[3] = '{0, 1, 7'd0,  8'h00, 0, 8'h01};
      vecs[4] = '{1, 0, 7'd95, 8'h7E, 1, 8'h00};
      vecs[5] = '{0, 1, 7'd95, 8'h00, 0, 8'h7E};
      vecs[6] = '{1, 0, 7'd96, 8'hAA, 0, 8'h00};
      vecs[7] = '{0, 1, 7'd1,  8'h00, 0, 8'h00};
      vecs[8] = '{1, 0, 7'd3,  8'hC3, 1, 8'h00};
      vecs[9] = '{0, 1, 7'd3,  8'h00, 0, 8'hC3};

      exp_cfg = CR;
      repeat (3) @(negedge clk);
      chkw("reset_config", config_bus, CR);
      chk8("reset_cfg5", config_bus[47:40], 8'hA5);
      chk8("reset_rdata", read_data, 8'h00);
      chk8("reset_ack", {7'd0, write_ack}, 8'h00);
      chk8("reset_err", err_count, 8'h00);
      rstn_n = 1'b1;

      // Timed write: commit SYNC_STAGES+1 clk after the strobe rises, one ack for a 10 clk hold.
      @(negedge clk);
      addr = 7'd3; wdata = 8'h5C; write_en = 1'b1;
      acks = 0;
      @(negedge clk);
      chk8("wr_t1_cfg3", config_bus[31:24], 8'h00);
      @(negedge clk);
      chk8("wr_t2_cfg3", config_bus[31:24], 8'h00);
      chk8("wr_t2_ack", {7'd0, write_ack}, 8'h00);
      @(negedge clk);
      chk8("wr_t3_cfg3", config_bus[31:24], 8'h5C);
      chk8("wr_t3_ack", {7'd0, write_ack}, 8'h01);
      acks += int'(write_ack);
      repeat (7) begin
         @(negedge clk);
         acks += int'(write_ack);
      end
      write_en = 1'b0;
      repeat (5) begin
         @(negedge clk);
         acks += int'(write_ack);
      end
      chk8("wr_hold_acks", 8'(acks), 8'd1);
      exp_cfg[3*8 +: 8] = 8'h5C;

      for (int i = 0; i < 10; i++) begin
         access(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].d, 6, acks);
         if (vecs[i].wr && vecs[i].a < 7'd96) exp_cfg[vecs[i].a*8 +: 8] = vecs[i].d;
         chk8($sformatf("vec%0d_acks", i), 8'(acks), 8'(vecs[i].acks));
         chkw($sformatf("vec%0d_config", i), config_bus, exp_cfg);
         chk8($sformatf("vec%0d_err", i), err_count, 8'h00);
         if (vecs[i].rd) chk8($sformatf("vec%0d_rdata", i), read_data, vecs[i].rdata);
      end

      // Write and read of reg7 in the same cycle: read returns the old value.
      access(1, 1, 7'd7, 8'hFF, 6, acks);
      exp_cfg[7*8 +: 8] = 8'hFF;
      chk8("same_rdata", read_data, 8'h00);
      chk8("same_cfg7", config_bus[63:56], 8'hFF);
      chk8("same_acks", 8'(acks), 8'd1);
      access(0, 1, 7'd7, 8'h00, 6, acks);
      chk8("reread7", read_data, 8'hFF);

      // Snapshot coherence across the status block.
      status_bus[7:0] = 8'h11; status_bus[15:8] = 8'h22;
      access(0, 1, 7'd96, 8'h00, 6, acks);
      chk8("snap_s0", read_data, 8'h11);
      status_bus[15:8] = 8'h33;
      access(0, 1, 7'd97, 8'h00, 6, acks);
      chk8("snap_s1", read_data, 8'h22);
      access(0, 1, 7'd97, 8'h00, 6, acks);
      chk8("snap_s1_again", read_data, 8'h22);
      access(0, 1, 7'd96, 8'h00, 6, acks);
      chk8("snap_reload_s0", read_data, 8'h11);
      access(0, 1, 7'd97, 8'h00, 6, acks);
      chk8("snap_reload_s1", read_data, 8'h33);

`ifdef REG_MAP_STATUS_STICKY_EN
      status_bus = '0;
      access(0, 1, 7'd96, 8'h00, 6, acks);
      @(negedge clk);
      status_bus[0] = 1'b1;
      @(negedge clk);
      status_bus[0] = 1'b0;
      access(0, 1, 7'd96, 8'h00, 6, acks);
      chk8("sticky_bit0_set", read_data, 8'h01);
      access(0, 1, 7'd96, 8'h00, 6, acks);
      chk8("sticky_bit0_clear", read_data, 8'h00);
`endif

      // Unmapped accesses: simultaneous pair counts once, then saturation.
      access(1, 1, 7'd127, 8'h55, 6, acks);
      chk8("unm_pair_err", err_count, 8'd1);
      chk8("unm_pair_rdata", read_data, 8'h00);
      chk8("unm_pair_acks", 8'(acks), 8'd0);
      access(1, 0, 7'd120, 8'h5A, 6, acks);
      chk8("unm_wr_err", err_count, 8'd2);
      chk8("unm_wr_acks", 8'(acks), 8'd0);
      chkw("unm_wr_config", config_bus, exp_cfg);
      for (int i = 0; i < 300; i++) begin
         access(0, 1, 7'(112 + (i % 16)), 8'h00, 3, acks);
         if (i == 251) chk8("err_254", err_count, 8'd254);
         if (i == 252) chk8("err_255", err_count, 8'd255);
      end
      chk8("err_saturated", err_count, 8'd255);
      chkw("unm_reads_config", config_bus, exp_cfg);

      // Reset mid-transaction drops the pending write and restores config.
      @(negedge clk);
      addr = 7'd20; wdata = 8'h99; write_en = 1'b1;
      @(negedge clk);
      rstn_n = 1'b0;
      #1;
      chkw("midrst_config", config_bus, CR);
      chk8("midrst_err", err_count, 8'h00);
      chk8("midrst_rdata", read_data, 8'h00);
      @(negedge clk);
      write_en = 1'b0;
      @(negedge clk);
      rstn_n = 1'b1;
      repeat (6) @(negedge clk);
      chk8("midrst_cfg20", config_bus[167:160], 8'h00);
      chk8("midrst_ack", {7'd0, write_ack}, 8'h00);

      // Strobe held through reset release gives exactly one write.
      addr = 7'd10; wdata = 8'h3C; write_en = 1'b1;
      @(negedge clk);
      rstn_n = 1'b0;
      @(negedge clk);
      rstn_n = 1'b1;
      acks = 0;
      repeat (10) begin
         @(negedge clk);
         acks += int'(write_ack);
      end
      write_en = 1'b0;
      repeat (5) begin
         @(negedge clk);
         acks += int'(write_ack);
      end
      exp_cfg = CR;
      exp_cfg[10*8 +: 8] = 8'h3C;
      chk8("heldrst_acks", 8'(acks), 8'd1);
      chkw("heldrst_config", config_bus, exp_cfg);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/register_map_sync.md
Name: register_map_sync

Overview:
- Parametrised successor to the SPI-fed config/status register map. It adds strobe synchronisation, per-register config reset values, coherent status snapshots and out-of-range access counting.
- Sits between spi_slave_mem_interface (strobes and address/data sourced from the sck domain) and the user logic driving config_bus_o and status_bus_i.
- All state is clocked on clk_i.

Parameters:
- ADDR_WIDTH, 7, address width; NUM_CONFIG_REG+NUM_STATUS_REG <= 2**ADDR_WIDTH (elaboration error otherwise).
- DATA_WIDTH, 8, register width.
- NUM_CONFIG_REG, 96, number of R/W config registers, addresses 0..NUM_CONFIG_REG-1.
- NUM_STATUS_REG, 32, number of RO status registers, addresses NUM_CONFIG_REG..NUM_CONFIG_REG+NUM_STATUS_REG-1.
- CONFIG_RESET, {DATA_WIDTH*NUM_CONFIG_REG{1'b0}}, packed reset value; reg k uses bits [k*DATA_WIDTH +: DATA_WIDTH].
- SYNC_STAGES, 2, synchroniser depth for the strobes; must be >= 2.

Ports:
- clk_i  input  1  system clock.
- rstn_n  input  1  reset; asynchronous, active-low.
- addr_i  input  ADDR_WIDTH  register address; stable while either strobe is high.
- write_data_i  input  DATA_WIDTH  write data; stable while write_en_i is high.
- write_en_i  input  1  write strobe, asynchronous to clk_i, level-held.
- read_en_i  input  1  read strobe, asynchronous to clk_i, level-held.
- read_data_o  output  DATA_WIDTH  registered read data.
- config_bus_o  output  DATA_WIDTH*NUM_CONFIG_REG  packed config registers; reg k at [k*DATA_WIDTH +: DATA_WIDTH].
- status_bus_i  input  DATA_WIDTH*NUM_STATUS_REG  packed live status, same packing.
- write_ack_o  output  1  one-cycle pulse when a config write commits.
- err_count_o  output  8  saturating count of out-of-range accesses.

Behaviour:
- Reset values (async assert, sync release):
  - config regs = CONFIG_RESET.
  - read_data_o = 0, snapshot = 0, write_ack_o = 0, err_count_o = 0.
  - all synchroniser and edge-detect flops = 0.
- Strobe path:
  - write_en_i and read_en_i each pass through a SYNC_STAGES flop chain.
  - A rising-edge detect on the last stage gives a one-cycle pulse, wr_p or rd_p, SYNC_STAGES+1 clk after the strobe rises.
  - A strobe held high yields exactly one pulse.
  - A strobe held high through reset release yields one pulse after release.
- On wr_p:
  - addr < NUM_CONFIG_REG: config[addr] <= write_data_i, and write_ack_o = 1 on the next cycle.
  - Status or unmapped address: no write, no ack; an unmapped address increments err_count_o (saturates at 255).
- On rd_p, read_data_o is updated the next cycle:
  - Config address: read_data_o <= config[addr].
  - Status address s = addr-NUM_CONFIG_REG: read_data_o <= snapshot[s]. When s==0, the whole snapshot is first reloaded from status_bus_i and read_data_o takes the new status[0] value. This makes a multi-byte read starting at status base coherent.
  - Unmapped address: read_data_o <= 0 and err_count_o increments.
- read_data_o holds its value between reads.
- Required upstream margin: read_en_i high >= SYNC_STAGES+2 clk before the first SDO bit is sampled.
- Write and read pulses in the same cycle:
  - The write commits.
  - Read data returns the pre-write value.
  - err_count_o increments by at most 1 per cycle, even if both accesses are unmapped.
- Reset mid-transaction: pending pulses are lost, and config returns to CONFIG_RESET.
- status_bus_i is treated as quasi-static; there is no per-bit synchronisation.

Optional Feature:
- Macro: REG_MAP_STATUS_STICKY_EN.
- Defined:
  - A sticky accumulator acc updates every clk as acc <= acc | status_bus_i.
  - A read of status base loads snapshot <= acc | status_bus_i, and in the same cycle acc <= status_bus_i, so no new 1s are lost.
  - acc resets to 0.
- Undefined: there is no accumulator, and the snapshot loads live status_bus_i.

Test Plan:
- Reset with CONFIG_RESET reg5=0xA5, others 0 -> config_bus_o[47:40]==0xA5, all other outputs 0.
- Write addr 3 data 0x5C with strobe held 10 clk -> config reg3==0x5C after SYNC_STAGES+1 clk; exactly one write_ack_o pulse.
- status reg0=0x11, reg1=0x22; read addr 96, change reg1 to 0x33, then read addr 97 -> read_data_o 0x11 then 0x22 (snapshot). Next read of 97 without re-reading 96 still returns 0x22.
- NUM_CONFIG_REG=96, NUM_STATUS_REG=16: write addr 120, then 300 further unmapped reads -> no config change; err_count_o==255.
- Write and read of addr 7 aligned to the same clk, old value 0x00, data 0xFF -> read_data_o==0x00; config reg7==0xFF.
- With REG_MAP_STATUS_STICKY_EN: 1-clk pulse on status bit0, then read addr 96 -> bit0 reads 1. Read addr 96 again with status 0 -> bit0 reads 0.
